// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - stall/flush control bundle between pipeline_ctrl and the datapath
// master: the controller side; slave: the pipeline registers and data memory side.
interface pipeline_ctrl_if #(
  parameter int STALL_CNT_W = 32
);
  logic [4:0]             id_rs_addr;
  logic [4:0]             id_rt_addr;
  logic                   id_rs_used;
  logic                   id_rt_used;
  logic                   id_branch_taken;
  logic                   exe_GPR_we;
  logic [4:0]             exe_GPR_waddr;
  logic                   exe_load;
  logic                   mem_mem_access;
  logic                   dmem_ack;
  logic                   pc_ena;
  logic                   if_id_ena;
  logic                   if_id_flush;
  logic                   id_exe_ena;
  logic                   id_exe_flush;
  logic                   exe_mem_ena;
  logic                   mem_wb_ena;
  logic                   mem_wb_flush;
  logic                   dmem_req;
  logic                   mem_err;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [1:0]             state;

  modport master (
    input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_branch_taken,
           exe_GPR_we, exe_GPR_waddr, exe_load, mem_mem_access, dmem_ack,
    output pc_ena, if_id_ena, if_id_flush, id_exe_ena, id_exe_flush,
           exe_mem_ena, mem_wb_ena, mem_wb_flush, dmem_req, mem_err,
           stall_cycles, state
  );

  modport slave (
    output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_branch_taken,
           exe_GPR_we, exe_GPR_waddr, exe_load, mem_mem_access, dmem_ack,
    input  pc_ena, if_id_ena, if_id_flush, id_exe_ena, id_exe_flush,
           exe_mem_ena, mem_wb_ena, mem_wb_flush, dmem_req, mem_err,
           stall_cycles, state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline stall/flush controller
// Load-use hazard stalls, data-memory wait sequencing with timeout, stall cycle counter.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STALL_CNT_W = 32
) (
  input logic           clk,
  input logic           reset,
  pipeline_ctrl_if.master ctrl_if
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mem_err_q, mem_err_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic hazard;
  logic dmem_req;
  logic timeout;
  logic mwait;
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = ctrl_if.id_rs_used && (ctrl_if.id_rs_addr == ctrl_if.exe_GPR_waddr);
  assign rt_hit = ctrl_if.id_rt_used && (ctrl_if.id_rt_addr == ctrl_if.exe_GPR_waddr);
  assign hazard = ctrl_if.exe_load && ctrl_if.exe_GPR_we &&
                  (ctrl_if.exe_GPR_waddr != 5'd0) && (rs_hit || rt_hit);

  assign dmem_req = ((state_q == ST_RUN) && ctrl_if.mem_mem_access) ||
                    (state_q == ST_MEM_WAIT);
  // An expired timeout releases the pipeline exactly like an ack would.
  assign timeout  = (state_q == ST_MEM_WAIT) && (cnt_q == CNT_W'(MEM_TIMEOUT));
  assign mwait    = dmem_req && !ctrl_if.dmem_ack && !timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (mwait) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mwait) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
          if (timeout && !ctrl_if.dmem_ack) begin
            mem_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ctrl_if.pc_ena       = 1'b1;
    ctrl_if.if_id_ena    = 1'b1;
    ctrl_if.if_id_flush  = 1'b0;
    ctrl_if.id_exe_ena   = 1'b1;
    ctrl_if.id_exe_flush = 1'b0;
    ctrl_if.exe_mem_ena  = 1'b1;
    ctrl_if.mem_wb_ena   = 1'b1;
    ctrl_if.mem_wb_flush = 1'b0;
    if (mwait) begin
      ctrl_if.pc_ena       = 1'b0;
      ctrl_if.if_id_ena    = 1'b0;
      ctrl_if.id_exe_ena   = 1'b0;
      ctrl_if.exe_mem_ena  = 1'b0;
      ctrl_if.mem_wb_flush = 1'b1;
    end else if (hazard) begin
      // Branch is ignored here; it re-resolves once the bubble reaches EXE.
      ctrl_if.pc_ena       = 1'b0;
      ctrl_if.if_id_ena    = 1'b0;
      ctrl_if.id_exe_flush = 1'b1;
    end else begin
      ctrl_if.if_id_flush  = ctrl_if.id_branch_taken;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!ctrl_if.pc_ena && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  assign ctrl_if.dmem_req     = dmem_req;
  assign ctrl_if.mem_err      = mem_err_q;
  assign ctrl_if.stall_cycles = stall_q;
  assign ctrl_if.state        = state_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_pipeline_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipeline_ctrl_if #(.STALL_CNT_W(4)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.id_rs_addr      = 5'd0;
    bus.id_rt_addr      = 5'd0;
    bus.id_rs_used      = 1'b0;
    bus.id_rt_used      = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.exe_GPR_we      = 1'b0;
    bus.exe_GPR_waddr   = 5'd0;
    bus.exe_load        = 1'b0;
    bus.mem_mem_access  = 1'b0;
    bus.dmem_ack        = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] waddr);
    bus.exe_load      = 1'b1;
    bus.exe_GPR_we    = 1'b1;
    bus.exe_GPR_waddr = waddr;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.pc_ena, bus.if_id_ena, bus.id_exe_ena, bus.exe_mem_ena, bus.mem_wb_ena} !== 5'b11111) begin
      failures++; $display("FAIL reset_enables got=%b exp=11111",
        {bus.pc_ena, bus.if_id_ena, bus.id_exe_ena, bus.exe_mem_ena, bus.mem_wb_ena});
    end
    checks++;
    if ({bus.if_id_flush, bus.id_exe_flush, bus.mem_wb_flush, bus.dmem_req, bus.mem_err} !== 5'b00000) begin
      failures++; $display("FAIL reset_flushes got=%b exp=00000",
        {bus.if_id_flush, bus.id_exe_flush, bus.mem_wb_flush, bus.dmem_req, bus.mem_err});
    end
    checks++;
    if (bus.stall_cycles !== 4'd0 || bus.state !== 2'd0) begin
      failures++; $display("FAIL reset_regs stall=%0d state=%0d exp 0 0", bus.stall_cycles, bus.state);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load(5'd5);
    bus.id_rt_addr = 5'd5;
    bus.id_rt_used = 1'b1;
    #1;
    checks++;
    if ({bus.pc_ena, bus.if_id_ena, bus.id_exe_ena, bus.id_exe_flush, bus.exe_mem_ena, bus.mem_wb_ena} !== 6'b001111) begin
      failures++; $display("FAIL lu_rt_outputs got=%b exp=001111",
        {bus.pc_ena, bus.if_id_ena, bus.id_exe_ena, bus.id_exe_flush, bus.exe_mem_ena, bus.mem_wb_ena});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (bus.stall_cycles !== 4'd1 || bus.pc_ena !== 1'b1) begin
      failures++; $display("FAIL lu_count stall=%0d pc_ena=%b exp 1 1", bus.stall_cycles, bus.pc_ena);
    end
    // rt matches but is unused; rs unused too
    set_load(5'd7);
    bus.id_rt_addr = 5'd7;
    #1;
    checks++;
    if (bus.pc_ena !== 1'b1) begin
      failures++; $display("FAIL lu_unused pc_ena=%b exp=1", bus.pc_ena);
    end
    bus.id_rs_addr = 5'd7;
    bus.id_rs_used = 1'b1;
    #1;
    checks++;
    if (bus.pc_ena !== 1'b0 || bus.id_exe_flush !== 1'b1) begin
      failures++; $display("FAIL lu_rs pc_ena=%b flush=%b exp 0 1", bus.pc_ena, bus.id_exe_flush);
    end
    bus.exe_GPR_waddr = 5'd0;
    bus.id_rs_addr    = 5'd0;
    bus.id_rt_addr    = 5'd0;
    bus.id_rt_used    = 1'b1;
    #1;
    checks++;
    if (bus.pc_ena !== 1'b1 || bus.id_exe_flush !== 1'b0) begin
      failures++; $display("FAIL lu_r0 pc_ena=%b flush=%b exp 1 0", bus.pc_ena, bus.id_exe_flush);
    end
    bus.exe_GPR_waddr = 5'd3;
    bus.id_rs_addr    = 5'd3;
    bus.exe_load      = 1'b0;
    #1;
    checks++;
    if (bus.pc_ena !== 1'b1) begin
      failures++; $display("FAIL lu_noload pc_ena=%b exp=1", bus.pc_ena);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (bus.stall_cycles !== 4'd1) begin
      failures++; $display("FAIL lu_count2 stall=%0d exp=1", bus.stall_cycles);
    end
  endtask

  task automatic test_mem_ack();
    do_reset();
    bus.mem_mem_access = 1'b1;
    bus.dmem_ack       = 1'b1;
    #1;
    checks++;
    if (bus.pc_ena !== 1'b1 || bus.dmem_req !== 1'b1 || bus.mem_wb_flush !== 1'b0) begin
      failures++; $display("FAIL ack_same pc=%b req=%b mwf=%b exp 1 1 0", bus.pc_ena, bus.dmem_req, bus.mem_wb_flush);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.stall_cycles !== 4'd0) begin
      failures++; $display("FAIL ack_after state=%0d stall=%0d exp 0 0", bus.state, bus.stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    logic [1:0] exp_state;
    do_reset();
    bus.mem_mem_access = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.dmem_ack = (c == 3);
      exp_state    = (c == 0) ? 2'd0 : 2'd1;
      #1;
      checks++;
      if (bus.state !== exp_state || bus.pc_ena !== (c == 3) || bus.mem_wb_flush !== (c != 3) ||
          bus.dmem_req !== 1'b1 || bus.mem_wb_ena !== 1'b1) begin
        failures++; $display("FAIL wait_c%0d state=%0d pc=%b mwf=%b req=%b mwe=%b exp state=%0d pc=%b",
          c, bus.state, bus.pc_ena, bus.mem_wb_flush, bus.dmem_req, bus.mem_wb_ena, exp_state, (c == 3));
      end
      @(negedge clk);
    end
    clear_inputs();
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.stall_cycles !== 4'd3 || bus.mem_err !== 1'b0) begin
      failures++; $display("FAIL wait_end state=%0d stall=%0d err=%b exp 0 3 0", bus.state, bus.stall_cycles, bus.mem_err);
    end
    // fresh access straight after release starts again from RUN
    bus.mem_mem_access = 1'b1;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.pc_ena !== 1'b0) begin
      failures++; $display("FAIL wait_fresh req=%b pc=%b exp 1 0", bus.dmem_req, bus.pc_ena);
    end
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    bus.mem_mem_access = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.pc_ena !== (c == 4) || bus.dmem_req !== 1'b1 || bus.mem_err !== 1'b0) begin
        failures++; $display("FAIL to_c%0d pc=%b req=%b err=%b exp pc=%b req=1 err=0",
          c, bus.pc_ena, bus.dmem_req, bus.mem_err, (c == 4));
      end
      @(negedge clk);
      if (c == 3) bus.mem_mem_access = 1'b0;
    end
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.mem_err !== 1'b1 || bus.stall_cycles !== 4'd4) begin
      failures++; $display("FAIL to_end state=%0d err=%b stall=%0d exp 0 1 4", bus.state, bus.mem_err, bus.stall_cycles);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_err !== 1'b1) begin
      failures++; $display("FAIL to_sticky err=%b exp=1", bus.mem_err);
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_load(5'd9);
    bus.id_rs_addr      = 5'd9;
    bus.id_rs_used      = 1'b1;
    bus.id_branch_taken = 1'b1;
    #1;
    checks++;
    if (bus.if_id_flush !== 1'b0 || bus.id_exe_flush !== 1'b1) begin
      failures++; $display("FAIL br_hazard iff=%b ief=%b exp 0 1", bus.if_id_flush, bus.id_exe_flush);
    end
    @(negedge clk);
    bus.exe_load = 1'b0;
    #1;
    checks++;
    if (bus.if_id_flush !== 1'b1 || bus.pc_ena !== 1'b1) begin
      failures++; $display("FAIL br_taken iff=%b pc=%b exp 1 1", bus.if_id_flush, bus.pc_ena);
    end
    bus.exe_load       = 1'b1;
    bus.mem_mem_access = 1'b1;
    #1;
    checks++;
    if (bus.if_id_flush !== 1'b0 || bus.id_exe_flush !== 1'b0 || bus.mem_wb_flush !== 1'b1) begin
      failures++; $display("FAIL br_mwait iff=%b ief=%b mwf=%b exp 0 0 1", bus.if_id_flush, bus.id_exe_flush, bus.mem_wb_flush);
    end
    @(negedge clk);
    bus.exe_load = 1'b0;
    bus.dmem_ack = 1'b1;
    #1;
    checks++;
    if (bus.if_id_flush !== 1'b1 || bus.state !== 2'd1) begin
      failures++; $display("FAIL br_ack iff=%b state=%0d exp 1 1", bus.if_id_flush, bus.state);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus.mem_mem_access = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge clk);
    // mem_err now set by the timeout; enter a second wait
    @(negedge clk);
    @(negedge clk);
    bus.mem_mem_access = 1'b0;
    #1;
    checks++;
    if (bus.state !== 2'd1 || bus.dmem_req !== 1'b1 || bus.mem_err !== 1'b1) begin
      failures++; $display("FAIL rmw_pre state=%0d req=%b err=%b exp 1 1 1", bus.state, bus.dmem_req, bus.mem_err);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.dmem_req !== 1'b0 || bus.mem_err !== 1'b0 || bus.stall_cycles !== 4'd0) begin
      failures++; $display("FAIL rmw_async state=%0d req=%b err=%b stall=%0d exp 0 0 0 0",
        bus.state, bus.dmem_req, bus.mem_err, bus.stall_cycles);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    set_load(5'd4);
    bus.id_rt_addr = 5'd4;
    bus.id_rt_used = 1'b1;
    for (int c = 0; c < 20; c++) @(negedge clk);
    #1;
    checks++;
    if (bus.stall_cycles !== 4'd15) begin
      failures++; $display("FAIL sat stall=%0d exp=15", bus.stall_cycles);
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_load_use();
    test_mem_ack();
    test_mem_wait();
    test_timeout();
    test_branch();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
